// File: rtl/bcd_to_bin_serial.sv
// Serial packed-BCD to binary converter using reverse double-dabble.
// Each clock in CONV shifts {bcd, bin} right one bit, then subtracts 3 from every BCD nibble
// that is >= 8. After BIN_W iterations the bin part holds the binary value.
// An input with any nibble > 9 takes the ERR path and reports err with bin_out = 0.
//
// Ports:
//   clk_i      system clock, rising edge
//   rst_ni     asynchronous active-low reset
//   start_i    request conversion of bcd_in_i (ignored while busy_o)
//   bcd_in_i   packed BCD, [3:0] is the least significant digit
//   busy_o     conversion in progress
//   done_o     one-cycle pulse when bin_out_o / err_o are updated
//   bin_out_o  converted value, held until the next done
//   err_o      last accepted input had an illegal nibble, held until the next done
module bcd_to_bin_serial #(
   parameter int unsigned DIGITS = 4,
   parameter int unsigned BIN_W  = 14
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic [4*DIGITS-1:0]   bcd_in_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [BIN_W-1:0]      bin_out_o,
   output logic                  err_o
);

   localparam int unsigned BcdW  = 4 * DIGITS;
   localparam int unsigned WorkW = BcdW + BIN_W;
   localparam int unsigned CntW  = $clog2(BIN_W + 1);
   // Counter value seen on the edge that completes the final iteration.
   localparam logic [CntW-1:0] LastCnt = CntW'(BIN_W - 1);

   typedef enum logic [1:0] {
      StIdle,
      StConv,
      StErr
   } state_e;

   state_e             state_q, state_d;
   logic [WorkW-1:0]   work_q, work_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [BIN_W-1:0]   bin_q, bin_d;
   logic               err_q, err_d;
   logic               done_q, done_d;

   logic               bcd_bad;
   logic [WorkW-1:0]   work_iter;

   // Any nibble above 9 makes the whole input illegal.
   always_comb begin
      bcd_bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_in_i[4*i +: 4] > 4'd9) begin
            bcd_bad = 1'b1;
         end
      end
   end

   // One reverse double-dabble step: shift right, then correct each nibble independently.
   always_comb begin
      work_iter = work_q >> 1;
      for (int i = 0; i < DIGITS; i++) begin
         if (work_iter[BIN_W + 4*i +: 4] >= 4'd8) begin
            work_iter[BIN_W + 4*i +: 4] = work_iter[BIN_W + 4*i +: 4] - 4'd3;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      cnt_d   = cnt_q;
      bin_d   = bin_q;
      err_d   = err_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               work_d  = {bcd_in_i, {BIN_W{1'b0}}};
               cnt_d   = '0;
               state_d = bcd_bad ? StErr : StConv;
            end
         end
         StConv: begin
            work_d = work_iter;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
               bin_d   = work_iter[BIN_W-1:0];
               err_d   = 1'b0;
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         StErr: begin
            bin_d   = '0;
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         work_q  <= '0;
         cnt_q   <= '0;
         bin_q   <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         bin_q   <= bin_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   assign busy_o    = (state_q != StIdle);
   assign done_o    = done_q;
   assign bin_out_o = bin_q;
   assign err_o     = err_q;

endmodule

// File: tb/tb_bcd_to_bin_serial.sv
// Self-checking bench for bcd_to_bin_serial: directed scenarios plus random conversions
// compared against a decimal-arithmetic reference model.
module tb_bcd_to_bin_serial;

   localparam int unsigned DIGITS = 4;
   localparam int unsigned BIN_W  = 14;
   localparam int unsigned MaxWait = 40;

   logic                clk;
   logic                rst_n;
   logic                start;
   logic [4*DIGITS-1:0] bcd_in;
   logic                busy;
   logic                done;
   logic [BIN_W-1:0]    bin_out;
   logic                err;

   int n_checks = 0;
   int n_errors = 0;

   bcd_to_bin_serial #(
      .DIGITS (DIGITS),
      .BIN_W  (BIN_W)
   ) u_dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .start_i   (start),
      .bcd_in_i  (bcd_in),
      .busy_o    (busy),
      .done_o    (done),
      .bin_out_o (bin_out),
      .err_o     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Reference: plain decimal evaluation of the digits; illegal digit gives 0 with bad set.
   function automatic logic [31:0] model_bin(input logic [4*DIGITS-1:0] b, output bit bad);
      int v;
      int d;
      v   = 0;
      bad = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         d = int'(b[4*i +: 4]);
         if (d > 9) bad = 1'b1;
         v = v * 10 + d;
      end
      return bad ? 32'd0 : 32'(v);
   endfunction

   // Called at a falling edge; the following rising edge samples start (E0).
   // bcd_in is scrambled afterwards to show it is only sampled at acceptance.
   task automatic start_conv(input logic [4*DIGITS-1:0] b);
      start  = 1'b1;
      bcd_in = b;
      @(negedge clk);
      start  = 1'b0;
      bcd_in = 16'($urandom);
   endtask

   // Counts falling edges until done; also counts busy cycles seen before done.
   task automatic wait_done(output int cycles, output int busy_cycles);
      cycles      = 0;
      busy_cycles = 0;
      while (!done && cycles < MaxWait) begin
         if (busy) busy_cycles++;
         @(negedge clk);
         cycles++;
      end
   endtask

   // Full conversion from the falling edge before E0 to the falling edge inside the done cycle.
   task automatic do_conv(input logic [4*DIGITS-1:0] b, input string tag);
      int          cyc;
      int          bcyc;
      bit          bad;
      logic [31:0] exp_bin;
      exp_bin = model_bin(b, bad);
      start_conv(b);
      wait_done(cyc, bcyc);
      check_eq({tag, " latency"}, 32'(cyc), bad ? 32'd1 : 32'(BIN_W));
      check_eq({tag, " bin_out"}, 32'(bin_out), exp_bin);
      check_eq({tag, " err"}, 32'(err), 32'(bad));
      check_eq({tag, " busy_in_done"}, 32'(busy), 32'd0);
      if (!bad) check_eq({tag, " busy_cycles"}, 32'(bcyc), 32'(BIN_W));
   endtask

   task automatic check_no_done(input int n, input string tag);
      int seen;
      seen = 0;
      repeat (n) begin
         @(negedge clk);
         if (done) seen++;
      end
      check_eq(tag, 32'(seen), 32'd0);
   endtask

   initial begin
      int          cyc;
      int          bcyc;
      logic [15:0] r;
      rst_n  = 1'b0;
      start  = 1'b0;
      bcd_in = '0;
      repeat (2) @(negedge clk);
      check_eq("reset busy", 32'(busy), 32'd0);
      check_eq("reset done", 32'(done), 32'd0);
      check_eq("reset bin_out", 32'(bin_out), 32'd0);
      check_eq("reset err", 32'(err), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      do_conv(16'h0000, "zero");
      @(negedge clk);
      check_eq("zero done_pulse", 32'(done), 32'd0);

      do_conv(16'h9999, "max");
      @(negedge clk);
      check_eq("max done_pulse", 32'(done), 32'd0);

      // Back-to-back: second start issued in the done cycle of the first.
      do_conv(16'h0042, "b2b_first");
      do_conv(16'h1234, "b2b_second");
      @(negedge clk);

      do_conv(16'h12A4, "illegal");
      @(negedge clk);
      check_eq("illegal done_pulse", 32'(done), 32'd0);
      do_conv(16'h0007, "after_illegal");
      @(negedge clk);

      // Start while busy is ignored.
      start_conv(16'h0500);
      repeat (4) @(negedge clk);
      start  = 1'b1;
      bcd_in = 16'h0001;
      @(negedge clk);
      start  = 1'b0;
      wait_done(cyc, bcyc);
      check_eq("ignore latency", 32'(cyc), 32'(BIN_W - 5));
      check_eq("ignore bin_out", 32'(bin_out), 32'd500);
      check_no_done(20, "ignore extra_done");

      // Asynchronous reset mid-conversion.
      start_conv(16'h0815);
      repeat (7) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_eq("async busy", 32'(busy), 32'd0);
      check_eq("async done", 32'(done), 32'd0);
      check_eq("async bin_out", 32'(bin_out), 32'd0);
      check_eq("async err", 32'(err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      check_no_done(20, "async no_done");
      do_conv(16'h0815, "after_reset");
      @(negedge clk);

      // Random conversions, roughly one in five with an illegal digit, some back-to-back.
      for (int k = 0; k < 30; k++) begin
         r = '0;
         for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
         if ($urandom_range(0, 4) == 0) begin
            r[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
         end
         do_conv(r, "random");
         if ($urandom_range(0, 1) == 0) @(negedge clk);
      end
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
